dmem_subword_ctrl: RTL

//  Parametrised data memory with a valid/ready request/response handshake and configurable access latency.

---
 rtl/dmem_subword_ctrl.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_subword_ctrl.sv
// dmem_subword_ctrl
//  Data memory for the CPU MEM stage. It takes one request at a time over a
//  valid/ready handshake and answers after LATENCY clock edges. It supports
//  byte, halfword and word loads and stores. Sub-word loads are sign- or
//  zero-extended. Misaligned, out-of-range and reserved-size accesses are
//  flagged as errors and leave memory unchanged.
//
//  Ports
//   CLK        clock; all state changes on posedge
//   rst        asynchronous active-low reset
//   req_valid  request present         req_ready  block can accept a request
//   req_we     1 = store, 0 = load     req_size   00 byte, 01 half, 10 word, 11 reserved
//   req_signed sign-extend a sub-word load
//   req_addr   byte address            req_wdata  right-aligned store data
//   rsp_valid  response present        rsp_ready  consumer takes the response
//   rsp_rdata  load result (0 for stores/errors)
//   rsp_err    access rejected
module dmem_subword_ctrl #(
    parameter int unsigned DEPTH     = 2048,
    parameter logic [31:0] BASE_ADDR = 32'h10010000,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          signed_q, signed_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic [31:0]   mem_q [DEPTH];

    logic [31:0]   off_s;
    logic [IW-1:0] idx_s;
    logic          err_s;
    logic [3:0]    be_s;
    logic [31:0]   wr_rep_s;
    logic [31:0]   rd_word_s;
    logic [31:0]   wr_word_s;
    logic [31:0]   ld_sh_s;
    logic [31:0]   ld_val_s;
    logic          mem_we_s;

    // Address decode, error classification and lane steering for the latched request
    always_comb begin
        off_s     = addr_q - BASE_ADDR;
        idx_s     = off_s[IW+1:2];
        err_s     = 1'b0;
        be_s      = 4'b0000;
        wr_rep_s  = wdata_q;
        rd_word_s = mem_q[idx_s];
        wr_word_s = rd_word_s;
        ld_sh_s   = rd_word_s >> {addr_q[1:0], 3'b000};
        ld_val_s  = 32'h0000_0000;

        // off is compared as a byte offset so every bit of it takes part
        if ((addr_q < BASE_ADDR) || (off_s >= 32'(4 * DEPTH))) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end

        case (size_q)
            2'b00: begin
                be_s     = 4'b0001 << addr_q[1:0];
                wr_rep_s = {4{wdata_q[7:0]}};
                ld_val_s = signed_q ? {{24{ld_sh_s[7]}}, ld_sh_s[7:0]}
                                    : {24'h00_0000, ld_sh_s[7:0]};
            end
            2'b01: begin
                if (addr_q[0]) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_s;
                end
                be_s     = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_rep_s = {2{wdata_q[15:0]}};
                ld_val_s = signed_q ? {{16{ld_sh_s[15]}}, ld_sh_s[15:0]}
                                    : {16'h0000, ld_sh_s[15:0]};
            end
            2'b10: begin
                if (addr_q[1:0] != 2'b00) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_s;
                end
                be_s     = 4'b1111;
                wr_rep_s = wdata_q;
                ld_val_s = rd_word_s;
            end
            default: begin
                err_s    = 1'b1;
                be_s     = 4'b0000;
                ld_val_s = 32'h0000_0000;
            end
        endcase

        for (int i = 0; i < 4; i++) begin
            wr_word_s[8*i +: 8] = be_s[i] ? wr_rep_s[8*i +: 8] : rd_word_s[8*i +: 8];
        end
    end

    // Handshake FSM: accept, count LATENCY edges, complete access, hold response
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        we_d        = we_q;
        size_d      = size_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_we_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    size_d      = req_size;
                    signed_d    = req_signed;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    cnt_d       = {CW{1'b0}};
                    req_ready_d = 1'b0;
                    state_d     = ST_WAIT;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    if (err_s) begin
                        err_d   = 1'b1;
                        rdata_d = 32'h0000_0000;
                    end else if (we_q) begin
                        mem_we_s = 1'b1;
                        err_d    = 1'b0;
                        rdata_d  = 32'h0000_0000;
                    end else begin
                        err_d   = 1'b0;
                        rdata_d = ld_val_s;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rdata_d     = 32'h0000_0000;
                    err_d       = 1'b0;
                    req_ready_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = {CW{1'b0}};
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rdata_d     = 32'h0000_0000;
                err_d       = 1'b0;
            end
        endcase
    end

    // Control, response and latched-request registers
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0000_0000;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            we_q        <= we_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Storage array; no reset. A store in flight when rst asserts is lost
    // because the async reset has already moved the FSM out of WAIT.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_q[idx_s] <= wr_word_s;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
